// File: rtl/drain_pkg.sv
// Shared types for the FIFO drain arbiter: FSM encoding, source tags, buffer entry.
package drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  localparam logic SRC_D0 = 1'b0;
  localparam logic SRC_D1 = 1'b1;

  localparam int DATA_W = 6;

  typedef struct packed {
    logic              src;
    logic [DATA_W-1:0] data;
  } buf_entry_t;

endpackage

// File: rtl/d_fifo_drain_arbiter_if.sv
// Handshake bundle between the D0/D1 FIFOs, the arbiter and the downstream sink.
// DRAIN_COUNT_EN adds the per-source retire counters cnt_D0/cnt_D1.
interface d_fifo_drain_arbiter_if #(
  parameter int data_width = 6
);
  logic                  active_in;
  logic                  empty_D0;
  logic                  empty_D1;
  logic [data_width-1:0] data_in_D0;
  logic [data_width-1:0] data_in_D1;
  logic                  ready_out;
  logic                  D0_pop;
  logic                  D1_pop;
  logic [data_width-1:0] data_out;
  logic                  valid_out;
  logic                  src_out;
  logic                  idle_out;
`ifdef DRAIN_COUNT_EN
  logic [7:0]            cnt_D0;
  logic [7:0]            cnt_D1;

  modport slave (
    input  active_in, empty_D0, empty_D1, data_in_D0, data_in_D1, ready_out,
    output D0_pop, D1_pop, data_out, valid_out, src_out, idle_out, cnt_D0, cnt_D1
  );
  modport master (
    output active_in, empty_D0, empty_D1, data_in_D0, data_in_D1, ready_out,
    input  D0_pop, D1_pop, data_out, valid_out, src_out, idle_out, cnt_D0, cnt_D1
  );
`else
  modport slave (
    input  active_in, empty_D0, empty_D1, data_in_D0, data_in_D1, ready_out,
    output D0_pop, D1_pop, data_out, valid_out, src_out, idle_out
  );
  modport master (
    output active_in, empty_D0, empty_D1, data_in_D0, data_in_D1, ready_out,
    input  D0_pop, D1_pop, data_out, valid_out, src_out, idle_out
  );
`endif
endinterface

// File: rtl/out_buf2.sv
// Two-entry FIFO holding captured words until downstream accepts them.
// Caller guarantees no push when full and no pop when empty.
module out_buf2 import drain_pkg::*; #(
  parameter type entry_t = buf_entry_t
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  entry_t     push_dat,
  input  logic       pop,
  output entry_t     head_dat,
  output logic [1:0] occ
);

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] occ_q, occ_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign occ      = occ_q;

endmodule

// File: rtl/d_fifo_drain_arbiter.sv
// Round-robin drain of FIFOs D0/D1 into one valid/ready stream via a 2-entry buffer.
// Optional DRAIN_COUNT_EN adds 8-bit wrapping counters of words retired per source.
module d_fifo_drain_arbiter import drain_pkg::*; #(
  parameter int data_width = 6,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  d_fifo_drain_arbiter_if.slave   bus
);

  typedef struct packed {
    logic                  src;
    logic [data_width-1:0] data;
  } entry_t;

  localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);

  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       infl_vld_q, infl_vld_d;
  logic       infl_src_q, infl_src_d;
  logic       pop_vld, pop_src, room, retire;
  logic [1:0] occ;
  entry_t     push_dat, head_dat;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= SRC_D1;
      infl_vld_q   <= 1'b0;
      infl_src_q   <= SRC_D0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      infl_vld_q   <= infl_vld_d;
      infl_src_q   <= infl_src_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = pop_vld ? pop_src : last_grant_q;
    infl_vld_d   = pop_vld;
    infl_src_d   = pop_src;
    case (state_q)
      ST_IDLE:  if (bus.active_in) state_d = ST_RUN;
      ST_RUN:   if (!bus.active_in) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (bus.active_in)                   state_d = ST_RUN;
        else if (occ == 2'd0 && !infl_vld_q) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // A slot retiring this cycle counts as free; otherwise the 2-entry buffer
  // could only sustain one word every other cycle.
  always_comb begin
    pop_vld = 1'b0;
    pop_src = SRC_D0;
    room    = ({1'b0, occ} + {2'b00, infl_vld_q} - {2'b00, retire}) < DEPTH;
    if (state_q == ST_RUN && room) begin
      if (!bus.empty_D0 && !bus.empty_D1) begin
        pop_vld = 1'b1;
        pop_src = ~last_grant_q;
      end else if (!bus.empty_D0) begin
        pop_vld = 1'b1;
        pop_src = SRC_D0;
      end else if (!bus.empty_D1) begin
        pop_vld = 1'b1;
        pop_src = SRC_D1;
      end
    end
    bus.D0_pop   = pop_vld && (pop_src == SRC_D0);
    bus.D1_pop   = pop_vld && (pop_src == SRC_D1);
    bus.idle_out = (state_q == ST_IDLE);
  end

  always_comb begin
    push_dat.src  = infl_src_q;
    push_dat.data = (infl_src_q == SRC_D1) ? bus.data_in_D1 : bus.data_in_D0;
  end

  assign retire = (occ != 2'd0) && bus.ready_out;

  out_buf2 #(.entry_t(entry_t)) u_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (infl_vld_q),
    .push_dat (push_dat),
    .pop      (retire),
    .head_dat (head_dat),
    .occ      (occ)
  );

  assign bus.valid_out = (occ != 2'd0);
  assign bus.data_out  = head_dat.data;
  assign bus.src_out   = head_dat.src;

`ifdef DRAIN_COUNT_EN
  logic [7:0] cnt_d0_q, cnt_d0_d;
  logic [7:0] cnt_d1_q, cnt_d1_d;

  always_comb begin
    cnt_d0_d = cnt_d0_q;
    cnt_d1_d = cnt_d1_q;
    if (retire) begin
      if (head_dat.src == SRC_D0) cnt_d0_d = cnt_d0_q + 8'd1;
      else                        cnt_d1_d = cnt_d1_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_d0_q <= 8'd0;
      cnt_d1_q <= 8'd0;
    end else begin
      cnt_d0_q <= cnt_d0_d;
      cnt_d1_q <= cnt_d1_d;
    end
  end

  assign bus.cnt_D0 = cnt_d0_q;
  assign bus.cnt_D1 = cnt_d1_q;
`endif

endmodule
